operand_issue: RTL and testbench

// - Execute-issue stage directly upstream of the ALU: owns the register file, accepts decoded

---
 rtl/hydra_pkg.sv | 21 ++
 rtl/reg_file.sv | 32 +++
 rtl/operand_issue.sv | 88 ++++++++
 tb/tb_operand_issue.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hydra_pkg.sv
// Shared ALU class encodings and the writeback predicate used by the issue stage and the ALU.
package hydra_pkg;

  localparam logic [2:0] ARITH  = 3'b000;
  localparam logic [2:0] SHIFT  = 3'b001;
  localparam logic [2:0] LOGIC  = 3'b010;
  localparam logic [2:0] SET    = 3'b011;
  localparam logic [2:0] BRANCH = 3'b101;

  // Bubble opcode: never writes rd and makes the ALU produce zero.
  localparam logic [4:0] OP_NOP = 5'b11111;

  function automatic logic writes_rd(input logic [4:0] op);
    case (op[4:2])
      ARITH, SHIFT, LOGIC: return 1'b1;
      SET:                 return !op[1];
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: two combinational read ports, one synchronous write port, r0 reads as zero.
module reg_file #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16,
  parameter int RADDR = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RADDR-1:0] rd_addr_a,
  input  logic [RADDR-1:0] rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             wr_en,
  input  logic [RADDR-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] regs [NREGS];

  // NOTE: the array is cleared on reset, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en && wr_addr != '0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];

endmodule

// File: rtl/operand_issue.sv
// Issue stage ahead of the ALU: operand read with EX forwarding, EX register, writeback and
// taken-branch squash of the instruction accepted behind the branch.
module operand_issue
  import hydra_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 16,
  parameter int RADDR = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_ALUop,
  input  logic [RADDR-1:0] in_rs,
  input  logic [RADDR-1:0] in_rt,
  input  logic [RADDR-1:0] in_rd,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_use_imm,
  output logic [4:0]       ALUop,
  output logic [WIDTH-1:0] op1,
  output logic [WIDTH-1:0] op2,
  output logic             ex_valid,
  input  logic [WIDTH-1:0] alu_out_op,
  input  logic             alu_out_branch,
  output logic             branch_taken,
  output logic [WIDTH-1:0] branch_target
);

  logic [RADDR-1:0] ex_rd;
  logic [WIDTH-1:0] ex_imm;
  logic [WIDTH-1:0] rf_a, rf_b;
  logic [WIDTH-1:0] op1_next, op2_next;
  logic             ex_writes;
  logic             wb_en;

  assign in_ready      = !hold;
  assign ex_writes     = ex_valid && writes_rd(ALUop) && ex_rd != '0;
  assign wb_en         = ex_writes && !hold;
  assign branch_taken  = ex_valid && ALUop[4:2] == BRANCH && alu_out_branch;
  assign branch_target = ex_imm;

  reg_file #(.WIDTH(WIDTH), .NREGS(NREGS), .RADDR(RADDR)) u_reg_file (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (in_rs),
    .rd_addr_b (in_rt),
    .rd_data_a (rf_a),
    .rd_data_b (rf_b),
    .wr_en     (wb_en),
    .wr_addr   (ex_rd),
    .wr_data   (alu_out_op)
  );

  // The EX result is not in the register file yet, so a matching source takes it directly.
  always_comb begin
    op1_next = rf_a;
    op2_next = rf_b;
    if (ex_writes && in_rs == ex_rd) op1_next = alu_out_op;
    if (in_use_imm)                  op2_next = in_imm;
    else if (ex_writes && in_rt == ex_rd) op2_next = alu_out_op;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ALUop    <= '0;
      op1      <= '0;
      op2      <= '0;
      ex_valid <= 1'b0;
      ex_rd    <= '0;
      ex_imm   <= '0;
    end else if (!hold) begin
      ex_valid <= in_valid && !branch_taken;
      if (in_valid) begin
        ALUop  <= in_ALUop;
        op1    <= op1_next;
        op2    <= op2_next;
        ex_rd  <= in_rd;
        ex_imm <= in_imm;
      end else begin
        ALUop  <= OP_NOP;
      end
    end
  end

endmodule

// File: tb/tb_operand_issue.sv
// Scoreboard bench for operand_issue: directed issue vectors, a small ALU model, and a monitor
// comparing each completing EX instruction against queued expectations.
module tb_operand_issue;

  localparam logic [4:0] ADD  = 5'b00000;
  localparam logic [4:0] SUB  = 5'b00001;
  localparam logic [4:0] MUL  = 5'b00010;
  localparam logic [4:0] XORI = 5'b01010;
  localparam logic [4:0] SLT  = 5'b01100;
  localparam logic [4:0] SETN = 5'b01110;
  localparam logic [4:0] BEQ  = 5'b10100;

  typedef struct {
    logic [4:0]  op;
    logic [15:0] op1;
    logic [15:0] op2;
    logic        br;
    logic [15:0] tgt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, hold, in_valid, in_ready, in_use_imm;
  logic [4:0]  in_ALUop, ALUop;
  logic [3:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm, op1, op2, alu_out_op, branch_target;
  logic        ex_valid, alu_out_branch, branch_taken;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  operand_issue dut (
    .clk            (clk),
    .reset          (reset),
    .hold           (hold),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_ALUop       (in_ALUop),
    .in_rs          (in_rs),
    .in_rt          (in_rt),
    .in_rd          (in_rd),
    .in_imm         (in_imm),
    .in_use_imm     (in_use_imm),
    .ALUop          (ALUop),
    .op1            (op1),
    .op2            (op2),
    .ex_valid       (ex_valid),
    .alu_out_op     (alu_out_op),
    .alu_out_branch (alu_out_branch),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target)
  );

  // Reference ALU for the opcodes this bench issues.
  always_comb begin
    alu_out_op     = '0;
    alu_out_branch = 1'b0;
    case (ALUop)
      ADD:     alu_out_op = op1 + op2;
      SUB:     alu_out_op = op1 - op2;
      MUL:     alu_out_op = op1 * op2;
      XORI:    alu_out_op = op1 ^ op2;
      SLT:     alu_out_op = {15'b0, $signed(op1) < $signed(op2)};
      BEQ:     alu_out_branch = (op1 == op2);
      default: alu_out_op = '0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (ex_valid && !hold) begin
      if (sb.size() == 0) begin
        check("unexpected_ex_instr", 32'(ALUop), 32'h1ff);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ex_ALUop", 32'(ALUop), 32'(e.op));
        check("ex_op1", 32'(op1), 32'(e.op1));
        check("ex_op2", 32'(op2), 32'(e.op2));
        check("ex_branch_taken", 32'(branch_taken), 32'(e.br));
        if (e.br) check("ex_branch_target", 32'(branch_target), 32'(e.tgt));
      end
    end
  end

  task automatic drive(input logic [4:0] op, input logic [3:0] rs, input logic [3:0] rt,
                       input logic [3:0] rd, input logic [15:0] imm, input logic use_imm);
    in_valid   = 1'b1;
    in_ALUop   = op;
    in_rs      = rs;
    in_rt      = rt;
    in_rd      = rd;
    in_imm     = imm;
    in_use_imm = use_imm;
  endtask

  task automatic issue(input logic [4:0] op, input logic [3:0] rs, input logic [3:0] rt,
                       input logic [3:0] rd, input logic [15:0] imm, input logic use_imm,
                       input logic push, input logic [15:0] e1, input logic [15:0] e2,
                       input logic ebr);
    drive(op, rs, rt, rd, imm, use_imm);
    if (push) sb.push_back('{op: op, op1: e1, op2: e2, br: ebr, tgt: imm});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reads R[r] through op1 of an ADD to r0, which writes nothing.
  task automatic probe(input logic [3:0] r, input logic [15:0] val);
    issue(ADD, r, 4'd0, 4'd0, 16'd0, 1'b1, 1'b1, val, 16'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    hold  = 1'b0;
    drive(ADD, 4'd0, 4'd0, 4'd5, 16'd9, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset    = 1'b0;
    check("reset_ALUop", 32'(ALUop), 32'd0);
    check("reset_op1", 32'(op1), 32'd0);
    check("reset_op2", 32'(op2), 32'd0);
    check("reset_ex_valid", 32'(ex_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // Dependent pair with forwarding, then readback of both results.
    issue(ADD, 4'd0, 4'd0, 4'd1, 16'd5, 1'b1, 1'b1, 16'd0, 16'd5, 1'b0);
    issue(ADD, 4'd1, 4'd1, 4'd2, 16'd0, 1'b0, 1'b1, 16'd5, 16'd5, 1'b0);
    idle(1);
    probe(4'd2, 16'd10);
    probe(4'd1, 16'd5);

    // Taken branch squashes the XOR accepted behind it.
    issue(ADD, 4'd0, 4'd0, 4'd3, 16'd7, 1'b1, 1'b1, 16'd0, 16'd7, 1'b0);
    idle(1);
    issue(BEQ, 4'd3, 4'd3, 4'd0, 16'h0040, 1'b0, 1'b1, 16'd7, 16'd7, 1'b1);
    check("branch_taken", 32'(branch_taken), 32'd1);
    check("branch_target", 32'(branch_target), 32'h40);
    issue(XORI, 4'd1, 4'd0, 4'd4, 16'h00ff, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
    check("squash_ex_valid", 32'(ex_valid), 32'd0);
    idle(1);
    probe(4'd4, 16'd0);

    // SUB held in EX for three cycles; the next instruction waits on the inputs.
    issue(SUB, 4'd1, 4'd0, 4'd5, 16'd3, 1'b1, 1'b1, 16'd5, 16'd3, 1'b0);
    hold = 1'b1;
    drive(ADD, 4'd5, 4'd0, 4'd6, 16'd0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("hold_in_ready", 32'(in_ready), 32'd0);
    check("hold_ex_valid", 32'(ex_valid), 32'd1);
    check("hold_ALUop", 32'(ALUop), 32'(SUB));
    check("hold_op1", 32'(op1), 32'd5);
    hold = 1'b0;
    sb.push_back('{op: ADD, op1: 16'd2, op2: 16'd0, br: 1'b0, tgt: 16'd0});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    idle(1);
    probe(4'd5, 16'd2);
    probe(4'd6, 16'd2);

    // r0 ignores writes and never forwards.
    issue(ADD, 4'd0, 4'd0, 4'd0, 16'd7, 1'b1, 1'b1, 16'd0, 16'd7, 1'b0);
    issue(ADD, 4'd0, 4'd0, 4'd7, 16'd0, 1'b0, 1'b1, 16'd0, 16'd0, 1'b0);
    idle(1);
    probe(4'd0, 16'd0);

    // Signed set-less-than writes; set sub-op 10 and a not-taken branch do not.
    issue(ADD, 4'd0, 4'd0, 4'd8, 16'hfffe, 1'b1, 1'b1, 16'd0, 16'hfffe, 1'b0);
    issue(SLT, 4'd8, 4'd0, 4'd9, 16'd1, 1'b1, 1'b1, 16'hfffe, 16'd1, 1'b0);
    issue(SETN, 4'd8, 4'd0, 4'd10, 16'd1, 1'b1, 1'b1, 16'hfffe, 16'd1, 1'b0);
    issue(BEQ, 4'd1, 4'd0, 4'd11, 16'd6, 1'b1, 1'b1, 16'd5, 16'd6, 1'b0);
    idle(1);
    probe(4'd9, 16'd1);
    probe(4'd10, 16'd0);
    probe(4'd11, 16'd0);
    probe(4'd8, 16'hfffe);

    // Reset while a MUL is in EX discards it and clears the register file.
    issue(MUL, 4'd1, 4'd0, 4'd12, 16'd3, 1'b1, 1'b1, 16'd5, 16'd3, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midreset_ALUop", 32'(ALUop), 32'd0);
    check("midreset_op1", 32'(op1), 32'd0);
    check("midreset_op2", 32'(op2), 32'd0);
    check("midreset_ex_valid", 32'(ex_valid), 32'd0);
    check("midreset_branch_taken", 32'(branch_taken), 32'd0);
    probe(4'd1, 16'd0);
    probe(4'd2, 16'd0);
    probe(4'd12, 16'd0);

    idle(3);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
